// File: rtl/tl45_regfile.sv
// TL45 architectural register file: 16 x 32-bit, r0 hardwired to zero, two registered read ports,
// one commit port and a pending-write scoreboard. Define TL45_RF_BYPASS_EN for same-edge commit forwarding.
module tl45_regfile #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_pipe_stall,
    input  logic              i_rd_en,
    input  logic [REG_AW-1:0] i_sr1,
    input  logic [REG_AW-1:0] i_sr2,
    input  logic              i_claim_en,
    input  logic [REG_AW-1:0] i_claim_reg,
    input  logic              i_rf_en,
    input  logic [REG_AW-1:0] i_rf_reg,
    input  logic [DATA_W-1:0] i_rf_val,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_sr1_val,
    output logic [DATA_W-1:0] o_sr2_val,
    output logic              o_sr1_busy,
    output logic              o_sr2_busy
);

    localparam int NREG = 1 << REG_AW;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    logic [REG_AW-1:0] sr1_q, sr2_q;

    logic [REG_AW-1:0] rd_a1, rd_a2;
    logic [DATA_W-1:0] rd_v1, rd_v2;
    logic              rd_b1, rd_b2;
    logic              commit;
    logic              claim;

    assign commit = i_rf_en && (i_rf_reg != '0);
    assign claim  = i_claim_en && !i_pipe_stall && (i_claim_reg != '0);

    // While stalled the latched addresses are re-read so values and busy flags track late commits.
    always_comb begin
        rd_a1 = i_pipe_stall ? sr1_q : i_sr1;
        rd_a2 = i_pipe_stall ? sr2_q : i_sr2;

        rd_v1 = (rd_a1 == '0) ? '0 : regs[rd_a1];
        rd_v2 = (rd_a2 == '0) ? '0 : regs[rd_a2];
`ifdef TL45_RF_BYPASS_EN
        if (commit && (i_rf_reg == rd_a1)) rd_v1 = i_rf_val;
        if (commit && (i_rf_reg == rd_a2)) rd_v2 = i_rf_val;
`endif

        // A commit this cycle clears the bit; a claim this cycle only shows up next cycle.
        rd_b1 = (rd_a1 != '0) && busy[rd_a1] && !(i_rf_en && (i_rf_reg == rd_a1));
        rd_b2 = (rd_a2 != '0) && busy[rd_a2] && !(i_rf_en && (i_rf_reg == rd_a2));
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            // NOTE: the storage array is plain flops here, so it is reset like any other state.
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            busy       <= '0;
            sr1_q      <= '0;
            sr2_q      <= '0;
            o_rd_valid <= 1'b0;
            o_sr1_val  <= '0;
            o_sr2_val  <= '0;
            o_sr1_busy <= 1'b0;
            o_sr2_busy <= 1'b0;
        end else begin
            if (commit) regs[i_rf_reg] <= i_rf_val;

            // NOTE: the later non-blocking assignment wins, so a same-cycle claim overrides the commit clear.
            if (commit) busy[i_rf_reg]  <= 1'b0;
            if (claim)  busy[i_claim_reg] <= 1'b1;

            if (!i_pipe_stall) begin
                o_rd_valid <= i_rd_en;
                if (i_rd_en) begin
                    sr1_q <= i_sr1;
                    sr2_q <= i_sr2;
                end
            end

            if (i_pipe_stall || i_rd_en) begin
                o_sr1_val  <= rd_v1;
                o_sr2_val  <= rd_v2;
                o_sr1_busy <= rd_b1;
                o_sr2_busy <= rd_b2;
            end
        end
    end

endmodule

// File: tb/tb_tl45_regfile.sv
// Self-checking bench for tl45_regfile; expected read results are queued when a read is driven
// and popped after the edge that produces them. Honours TL45_RF_BYPASS_EN when defined.
module tb_tl45_regfile;

    localparam logic [31:0] K = 32'h0101_0101;
`ifdef TL45_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_pipe_stall = 1'b0;
    logic        i_rd_en = 1'b0;
    logic [3:0]  i_sr1 = '0;
    logic [3:0]  i_sr2 = '0;
    logic        i_claim_en = 1'b0;
    logic [3:0]  i_claim_reg = '0;
    logic        i_rf_en = 1'b0;
    logic [3:0]  i_rf_reg = '0;
    logic [31:0] i_rf_val = '0;
    logic        o_rd_valid;
    logic [31:0] o_sr1_val, o_sr2_val;
    logic        o_sr1_busy, o_sr2_busy;

    logic [66:0] obs;
    assign obs = {o_rd_valid, o_sr1_busy, o_sr2_busy, o_sr1_val, o_sr2_val};

    typedef struct {
        string       name;
        logic [66:0] bits;
    } exp_t;

    exp_t sb[$];
    int   applied = 0;
    int   miscompares = 0;

    tl45_regfile dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_pipe_stall (i_pipe_stall),
        .i_rd_en      (i_rd_en),
        .i_sr1        (i_sr1),
        .i_sr2        (i_sr2),
        .i_claim_en   (i_claim_en),
        .i_claim_reg  (i_claim_reg),
        .i_rf_en      (i_rf_en),
        .i_rf_reg     (i_rf_reg),
        .i_rf_val     (i_rf_val),
        .o_rd_valid   (o_rd_valid),
        .o_sr1_val    (o_sr1_val),
        .o_sr2_val    (o_sr2_val),
        .o_sr1_busy   (o_sr1_busy),
        .o_sr2_busy   (o_sr2_busy)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [66:0] pk(input logic v, input logic b1, input logic b2,
                                       input logic [31:0] a, input logic [31:0] b);
        return {v, b1, b2, a, b};
    endfunction

    task automatic drive(input logic stall, input logic rd_en, input logic [3:0] sr1, input logic [3:0] sr2,
                         input logic claim_en, input logic [3:0] claim_reg,
                         input logic rf_en, input logic [3:0] rf_reg, input logic [31:0] rf_val);
        i_pipe_stall = stall;
        i_rd_en      = rd_en;
        i_sr1        = sr1;
        i_sr2        = sr2;
        i_claim_en   = claim_en;
        i_claim_reg  = claim_reg;
        i_rf_en      = rf_en;
        i_rf_reg     = rf_reg;
        i_rf_val     = rf_val;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'h0);
    endtask

    task automatic push_exp(input string n, input logic v, input logic b1, input logic b2,
                            input logic [31:0] a, input logic [31:0] b);
        exp_t x;
        x.name = n;
        x.bits = pk(v, b1, b2, a, b);
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        idle();
        tick(); tick();
        #4 i_reset = 1'b0;
        push_exp("rst_idle", 0, 0, 0, 32'h0, 32'h0);
        tick();
        e = sb.pop_front(); applied++;
        if (obs !== e.bits) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, obs, e.bits); end

        drive(0, 0, 0, 0, 1, 15, 1, 1, 32'h1111_1111); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 15, 32'hFFFF_0000); tick();
        drive(0, 1, 1, 15, 1, 1, 0, 0, 32'h0);
        push_exp("claim_same_cycle", 1, 0, 0, 32'h1111_1111, 32'hFFFF_0000);
        tick();
        e = sb.pop_front(); applied++;
        if (obs !== e.bits) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, obs, e.bits); end
        drive(0, 1, 1, 15, 0, 0, 0, 0, 32'h0);
        push_exp("claim_next_cycle", 1, 1, 0, 32'h1111_1111, 32'hFFFF_0000);
        tick();
        e = sb.pop_front(); applied++;
        if (obs !== e.bits) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, obs, e.bits); end

        #4 i_reset = 1'b1;
        #1;
        applied++;
        if (obs !== 67'h0) begin miscompares++; $display("FAIL async_reset: got %h expected %h", obs, 67'h0); end
        idle();
        #2 i_reset = 1'b0;
        push_exp("post_reset_idle", 0, 0, 0, 32'h0, 32'h0);
        tick();
        e = sb.pop_front(); applied++;
        if (obs !== e.bits) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, obs, e.bits); end
        drive(0, 1, 1, 15, 0, 0, 0, 0, 32'h0);
        push_exp("post_reset_read", 1, 0, 0, 32'h0, 32'h0);
        tick();
        e = sb.pop_front(); applied++;
        if (obs !== e.bits) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, obs, e.bits); end
    endtask

    task automatic test_r0();
        exp_t e;
        drive(0, 1, 0, 0, 1, 0, 1, 0, 32'hDEAD_BEEF);
        push_exp("r0_same_edge", 1, 0, 0, 32'h0, 32'h0);
        tick();
        e = sb.pop_front(); applied++;
        if (obs !== e.bits) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, obs, e.bits); end
        drive(0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
        push_exp("r0_after", 1, 0, 0, 32'h0, 32'h0);
        tick();
        e = sb.pop_front(); applied++;
        if (obs !== e.bits) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, obs, e.bits); end
    endtask

    task automatic test_write_read();
        exp_t e;
        logic [31:0] fwd;
        drive(0, 0, 0, 0, 0, 0, 1, 3, 32'h1234_5678); tick();
        drive(0, 1, 3, 3, 0, 0, 0, 0, 32'h0);
        push_exp("write_then_read", 1, 0, 0, 32'h1234_5678, 32'h1234_5678);
        tick();
        e = sb.pop_front(); applied++;
        if (obs !== e.bits) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, obs, e.bits); end

        fwd = BYP ? 32'hAAAA_5555 : 32'h1234_5678;
        drive(0, 1, 3, 3, 0, 0, 1, 3, 32'hAAAA_5555);
        push_exp("same_edge_commit", 1, 0, 0, fwd, fwd);
        tick();
        e = sb.pop_front(); applied++;
        if (obs !== e.bits) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, obs, e.bits); end
        drive(0, 1, 3, 3, 0, 0, 0, 0, 32'h0);
        push_exp("same_edge_settled", 1, 0, 0, 32'hAAAA_5555, 32'hAAAA_5555);
        tick();
        e = sb.pop_front(); applied++;
        if (obs !== e.bits) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, obs, e.bits); end
    endtask

    task automatic test_scoreboard();
        exp_t e;
        logic [31:0] v;
        drive(0, 0, 0, 0, 1, 5, 0, 0, 32'h0); tick();
        drive(0, 1, 5, 5, 0, 0, 0, 0, 32'h0);
        push_exp("claim_busy", 1, 1, 1, 32'h0, 32'h0);
        tick();
        e = sb.pop_front(); applied++;
        if (obs !== e.bits) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, obs, e.bits); end

        v = BYP ? 32'd7 : 32'd0;
        drive(1, 0, 0, 0, 0, 0, 1, 5, 32'd7);
        push_exp("stall_commit_refresh", 1, 0, 0, v, v);
        tick();
        e = sb.pop_front(); applied++;
        if (obs !== e.bits) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, obs, e.bits); end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        push_exp("stall_commit_settled", 1, 0, 0, 32'd7, 32'd7);
        tick();
        e = sb.pop_front(); applied++;
        if (obs !== e.bits) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, obs, e.bits); end

        v = BYP ? 32'd9 : 32'd7;
        drive(0, 1, 5, 5, 1, 5, 1, 5, 32'd9);
        push_exp("claim_commit_same_read", 1, 0, 0, v, v);
        tick();
        e = sb.pop_front(); applied++;
        if (obs !== e.bits) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, obs, e.bits); end
        drive(0, 1, 5, 5, 0, 0, 0, 0, 32'h0);
        push_exp("claim_wins", 1, 1, 1, 32'd9, 32'd9);
        tick();
        e = sb.pop_front(); applied++;
        if (obs !== e.bits) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, obs, e.bits); end
        drive(0, 1, 5, 0, 0, 0, 1, 5, 32'd9);
        push_exp("commit_clears", 1, 0, 0, 32'd9, 32'd0);
        tick();
        e = sb.pop_front(); applied++;
        if (obs !== e.bits) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, obs, e.bits); end
    endtask

    task automatic test_stall_hold();
        exp_t e;
        logic [31:0] v2;
        drive(0, 0, 0, 0, 0, 0, 1, 2, 32'h2222_2222); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 4, 32'h4444_4444); tick();
        drive(0, 1, 2, 4, 0, 0, 0, 0, 32'h0);
        push_exp("read_r2_r4", 1, 0, 0, 32'h2222_2222, 32'h4444_4444);
        tick();
        e = sb.pop_front(); applied++;
        if (obs !== e.bits) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, obs, e.bits); end

        for (int c = 0; c < 3; c++) begin
            if (c == 0)      v2 = 32'h4444_4444;
            else if (c == 1) v2 = BYP ? 32'h4444_AAAA : 32'h4444_4444;
            else             v2 = 32'h4444_AAAA;
            drive(1, 1, 9, 9, 1, 9, (c == 1), 4, 32'h4444_AAAA);
            push_exp($sformatf("stall_hold_%0d", c), 1, 0, 0, 32'h2222_2222, v2);
            tick();
            e = sb.pop_front(); applied++;
            if (obs !== e.bits) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, obs, e.bits); end
        end

        drive(0, 1, 9, 9, 0, 0, 0, 0, 32'h0);
        push_exp("r9_claim_dropped", 1, 0, 0, 32'h0, 32'h0);
        tick();
        e = sb.pop_front(); applied++;
        if (obs !== e.bits) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, obs, e.bits); end
        idle();
        push_exp("idle_valid_low", 0, 0, 0, 32'h0, 32'h0);
        tick();
        e = sb.pop_front(); applied++;
        if (obs !== e.bits) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, obs, e.bits); end
        drive(1, 1, 2, 2, 0, 0, 0, 0, 32'h0);
        push_exp("stall_keeps_valid_low", 0, 0, 0, 32'h0, 32'h0);
        tick();
        e = sb.pop_front(); applied++;
        if (obs !== e.bits) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, obs, e.bits); end
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] v2;
        i_reset = 1'b1;
        idle();
        #2 i_reset = 1'b0;
        for (int i = 1; i < 16; i++) begin
            v2 = BYP ? 32'(i) * K : 32'h0;
            drive(0, 1, 4'(i - 1), 4'(i), 1, 4'(i), 1, 4'(i), 32'(i) * K);
            push_exp($sformatf("b2b_%0d", i), 1, (i > 1), 0, 32'(i - 1) * K, v2);
            tick();
            e = sb.pop_front(); applied++;
            if (obs !== e.bits) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, obs, e.bits); end
        end
        drive(0, 1, 15, 14, 0, 0, 0, 0, 32'h0);
        push_exp("b2b_final", 1, 1, 1, 32'd15 * K, 32'd14 * K);
        tick();
        e = sb.pop_front(); applied++;
        if (obs !== e.bits) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, obs, e.bits); end
        idle();
    endtask

    initial begin
        test_reset();
        test_r0();
        test_write_read();
        test_scoreboard();
        test_stall_hold();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
